// File: rtl/mult_div_unit_if.sv
// Operand, control and HI/LO result bundle for the iterative multiply/divide unit.
// The master is the datapath; the slave is mult_div_unit.
interface mult_div_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] src_a;
    logic [N-1:0] src_b;
    logic         hi_we;
    logic         lo_we;
    logic [N-1:0] wd;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO; one product or quotient bit per cycle.
// Latency N cycles from the start edge, with a one-cycle done pulse; start while busy is dropped (no queuing).
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]     state;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_q;
    logic           sign_a;
    logic           sign_b;
    logic           div_zero;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] work;
    logic [N-1:0]   hi_q;
    logic [N-1:0]   lo_q;
    logic           done_q;

    // Operand capture: magnitudes plus sign flags (signed ops are MULT/DIV, op[0]==0)
    logic           in_sign_a;
    logic           in_sign_b;
    logic [N-1:0]   in_mag_a;
    logic [N-1:0]   in_mag_b;

    always_comb begin
        in_sign_a = ~bus.op[0] & bus.src_a[N-1];
        in_sign_b = ~bus.op[0] & bus.src_b[N-1];
        in_mag_a  = in_sign_a ? (~bus.src_a + 1'b1) : bus.src_a;
        in_mag_b  = in_sign_b ? (~bus.src_b + 1'b1) : bus.src_b;
    end

    // One iteration. work holds {accumulator/remainder, multiplier/dividend-quotient}.
    logic [N:0]     msum;
    logic [N:0]     shifted;
    logic [N:0]     trial;
    logic [2*N-1:0] work_nx;

    always_comb begin
        msum    = {1'b0, work[2*N-1:N]} + (work[0] ? {1'b0, b_q} : {(N+1){1'b0}});
        shifted = {work[2*N-1:N], work[N-1]};
        trial   = shifted - {1'b0, b_q};
        if (op_q[1]) begin
            // Restoring step: keep the subtraction only if it did not go negative
            work_nx = {(trial[N] ? shifted[N-1:0] : trial[N-1:0]), work[N-2:0], ~trial[N]};
        end else begin
            work_nx = {msum, work[N-1:1]};
        end
    end

    // Sign correction applied to the value produced by the final iteration
    logic           neg_res;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
    logic [N-1:0]   res_hi;
    logic [N-1:0]   res_lo;

    always_comb begin
        neg_res  = sign_a ^ sign_b;
        prod_fix = neg_res ? (~work_nx + 1'b1) : work_nx;
        quo      = work_nx[N-1:0];
        rem      = work_nx[2*N-1:N];
        res_hi   = prod_fix[2*N-1:N];
        res_lo   = prod_fix[N-1:0];
        if (op_q[1]) begin
            // Remainder follows the dividend, which also returns src_a unchanged on divide-by-zero
            res_hi = sign_a ? (~rem + 1'b1) : rem;
            if (div_zero) begin
                res_lo = {N{1'b1}};
            end else begin
                res_lo = neg_res ? (~quo + 1'b1) : quo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= 2'b00;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            b_q      <= '0;
            work     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) begin
                        hi_q <= bus.wd;
                    end
                    if (bus.lo_we) begin
                        lo_q <= bus.wd;
                    end
                    if (bus.start) begin
                        op_q     <= bus.op;
                        sign_a   <= in_sign_a;
                        sign_b   <= in_sign_b;
                        div_zero <= bus.op[1] & (bus.src_b == '0);
                        b_q      <= in_mag_b;
                        work     <= {{N{1'b0}}, in_mag_a};
                        cnt      <= CW'(N - 1);
                        state    <= RUN;
                    end
                end
                default: begin
                    work <= work_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int N = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_unit_if #(.N(N)) bus();
    mult_div_unit #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {hi, lo} straight from the instruction semantics
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MULT:  return 64'(sa * sb);
            MULTU: return ua * ub;
            DIV: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                return {32'(a % b), 32'(a / b)};
            end
        endcase
    endfunction

    // Called at a negedge while idle; returns at the negedge after the start edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
    endtask

    // Counts busy cycles, optionally pokes start/MTHI mid-run, then checks the done cycle
    task automatic finish_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input bit disturb);
        logic [63:0] exp;
        logic [31:0] hold_hi;
        int n;
        exp     = model(op, a, b);
        hold_hi = bus.hi;
        n       = 0;
        while (bus.busy && n < 4 * N) begin
            n++;
            if (disturb && n == 5) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.src_a = ~a;
                bus.src_b = a;
                bus.hi_we = 1'b1;
                bus.wd    = 32'hDEAD_BEEF;
            end
            if (disturb && n == 6) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                check({tag, "_busy_hi_hold"}, 64'(bus.hi), 64'(hold_hi));
            end
            @(negedge clk);
        end
        check({tag, "_cycles"}, 64'(n), 64'(N));
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_result"}, {bus.hi, bus.lo}, exp);
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb);
        issue(op, a, b);
        finish_op(tag, op, a, b, disturb);
        @(negedge clk);
        check({tag, "_done_clear"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int pulses;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wd    = '0;
        repeat (2) @(negedge clk);
        check("rst_state", {30'b0, bus.busy, bus.done, bus.hi, bus.lo}, 66'b0);
        reset = 1'b0;
        @(negedge clk);

        // MTHI / MTLO in idle
        bus.hi_we = 1'b1; bus.wd = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'h0});
        bus.lo_we = 1'b1; bus.wd = 32'hCAFE_F00D;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'hCAFE_F00D});

        // Directed plan cases; the first one also pokes start and MTHI mid-run
        do_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op("mult_neg3x7", MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        do_op("mult_minxmin", MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("divu_100_7", DIVU, 32'd100, 32'd7, 1'b0);
        do_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_op("divu_by0", DIVU, 32'h1234, 32'd0, 1'b0);
        do_op("div_by0_neg", DIV, 32'h8765_4321, 32'd0, 1'b0);
        do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // MTLO on the same edge as start: visible during the run, then overwritten
        bus.lo_we = 1'b1; bus.wd = 32'h1357_9BDF;
        issue(MULTU, 32'd3, 32'd5);
        check("start_mtlo", 64'(bus.lo), 64'h1357_9BDF);
        finish_op("start_mtlo_op", MULTU, 32'd3, 32'd5, 1'b0);
        @(negedge clk);

        // Back-to-back: second start in the done cycle
        issue(DIVU, 32'd100, 32'd7);
        finish_op("b2b_first", DIVU, 32'd100, 32'd7, 1'b0);
        issue(MULT, 32'hFFFF_FFFD, 32'd7);
        finish_op("b2b_second", MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        @(negedge clk);

        // Asynchronous reset in cycle 10 of a MULTU
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_mid_op", {30'b0, bus.busy, bus.done, bus.hi, bus.lo}, 66'b0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        check("arst_no_done", 64'(pulses), 64'd0);

        // Random operations with corner-biased operands
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(0, 1000);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 50);
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit owning the HI/LO registers of the MIPS datapath.
- Sits directly downstream of register_file; operands come from the RD1/RD2 read ports.
- Executes MULT, MULTU, DIV and DIVU over N cycles with a start/busy/done handshake.
- HI/LO are read back (MFHI/MFLO) and written directly (MTHI/MTLO) through dedicated ports.

Parameters:
- N, 32, operand width and HI/LO width; iteration count equals N.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on clk edge.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src_a  input  N  multiplicand / dividend (from RD1).
- src_b  input  N  multiplier / divisor (from RD2).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wd  input  N  MTHI/MTLO write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO receive a result.
- hi  output  N  HI register.
- lo  output  N  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): hi=0, lo=0, busy=0, done=0, state IDLE, iteration counter=0. The in-flight operation is discarded.
- State machine has two states:
  - IDLE: busy=0. start=1 at edge k latches op, |src_a|, |src_b| and sign flags, loads counter=N-1, and moves to RUN.
  - RUN: busy=1 for exactly N cycles (after edges k..k+N-1). Each edge performs one iteration and decrements the counter. On the edge where counter==0 (edge k+N): writes HI/LO, sets done=1 for the following cycle, returns to IDLE.
- Latency: result is visible in hi/lo after edge k+N. done is high for exactly one cycle, coincident with the first cycle the new values are visible.
- start while busy=1 is ignored; no queuing.
- start in the done cycle is accepted, giving back-to-back operation.
- Operands are captured at the start edge. Later changes on src_a/src_b have no effect.
- Multiply: unsigned shift-add over a 2N-bit product. HI=product[2N-1:N], LO=product[N-1:0].
- Signed multiply: operate on magnitudes, then negate the 2N-bit product when sign_a XOR sign_b.
- Divide: restoring division, one quotient bit per cycle. LO=quotient, HI=remainder.
- Signed divide:
  - Quotient is negated when sign_a XOR sign_b.
  - Remainder takes the sign of the dividend.
  - Truncation is toward zero.
- Signed overflow: src_a=0x80000000, src_b=0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (src_b==0, DIV or DIVU): LO=all ones, HI=src_a as captured. No trap. Still takes N cycles and pulses done.
- hi_we/lo_we:
  - Applied only in IDLE; the register takes wd at the edge.
  - Ignored while busy=1.
  - If start and hi_we/lo_we are asserted at the same IDLE edge, the write is applied. The operation result overwrites it at completion.
- hi/lo hold their values at all other times. MFHI/MFLO read them combinationally through the outputs.

Test Plan:
1. MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF, start at edge k -> busy high for 32 cycles; after edge k+32, hi=0xFFFFFFFE, lo=0x00000001, done high one cycle.
2. MULT src_a=0xFFFFFFFD (-3), src_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
3. Divide cases:
   - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
   - DIV 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001.
4. Corner cases:
   - DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234, done after 32 cycles.
   - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Handshake checks:
   - start re-asserted with new operands mid-RUN -> ignored; original result delivered.
   - hi_we=1, wd=0xDEADBEEF while busy -> hi unchanged.
   - Same write in IDLE -> hi=0xDEADBEEF next cycle.
6. Reset and back-to-back:
   - Assert reset at cycle 10 of a MULTU -> hi=lo=0, busy=0, done=0 immediately (asynchronous). No done pulse after release.
   - start asserted in the done cycle -> second operation begins; busy high on the next cycle.
